// File: rtl/riscv_issue_pkg.sv
// riscv_issue_pkg: shared opcode constants, instruction classes and the canonical NOP
package riscv_issue_pkg;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [31:0] NOP_INST = 32'h00000013;
   typedef enum logic [2:0] {CLS_ALU, CLS_BR, CLS_LD, CLS_ST, CLS_ILL} inst_class_t;
endpackage

// File: rtl/inst_classify.sv
// inst_classify: decodes an RV32I word into issue class and register fields
module inst_classify
   import riscv_issue_pkg::*;
(
   input  logic [31:0] inst,
   output inst_class_t cls,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        writes_rd,
   output logic        uses_rs2
);
   logic [6:0] op;
   logic       unused_bits;
   // opcode class and register usage; only ALU and loads produce a result register
   always_comb begin
      op          = inst[6:0];
      unused_bits = ^{inst[31:25], inst[14:12]};
      cls = (op == OP_R || op == OP_I) ? CLS_ALU :
            (op == OP_BR) ? CLS_BR :
            (op == OP_LD) ? CLS_LD :
            (op == OP_ST) ? CLS_ST : CLS_ILL;
      rd        = inst[11:7];
      rs1       = inst[19:15];
      rs2       = inst[24:20];
      writes_rd = (cls == CLS_ALU) || (cls == CLS_LD);
      uses_rs2  = (op == OP_R) || (cls == CLS_BR) || (cls == CLS_ST);
   end
endmodule

// File: rtl/dual_issue_steer.sv
// dual_issue_steer: queued in-order dual issue into slot A (ALU/BR) and slot B (ALU/LD/ST); ISSUE_STATS_EN adds issue counters
module dual_issue_steer
   import riscv_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_inst,
   output logic        in_ready,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_a_valid,
   output logic [31:0] out_a_inst,
   output logic        out_b_valid,
   output logic [31:0] out_b_inst,
   output logic        out_b_first,
`ifdef ISSUE_STATS_EN
   output logic [31:0] dual_cnt,
   output logic [31:0] single_cnt,
`endif
   output logic        illegal
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1;
   logic [CNT_W-1:0] count_q, count_d, pops, pop_n;
   logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d, b_first_q, b_first_d;
   logic             illegal_q, illegal_d;
   logic [31:0]      a_inst_q, a_inst_d, b_inst_q, b_inst_d;
   logic [31:0]      h0, h1, g_a_inst, g_b_inst;
   inst_class_t      c0, c1;
   logic [4:0]       rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
   logic             wr0, u2_0, wr1, u2_1, unused_h0;
   logic             has0, has1, hazard, pair_a, pair_b, h0_a, h0_b;
   logic             g_a_valid, g_b_valid, g_b_first, g_ill, issue, push;

   inst_classify u_cls0 (.inst(h0), .cls(c0), .rd(rd0), .rs1(rs1_0), .rs2(rs2_0), .writes_rd(wr0), .uses_rs2(u2_0));
   inst_classify u_cls1 (.inst(h1), .cls(c1), .rd(rd1), .rs1(rs1_1), .rs2(rs2_1), .writes_rd(wr1), .uses_rs2(u2_1));

   // group formation from the two oldest entries; a hazard or branch/illegal head forces single issue
   always_comb begin
      head1     = head_q + PTR_W'(1);
      h0        = mem_q[head_q];
      h1        = mem_q[head1];
      unused_h0 = ^{rs1_0, rs2_0, u2_0};
      has0      = count_q != '0;
      has1      = count_q >= CNT_W'(2);
      hazard    = (wr0 && rd0 != 5'd0 && (rd0 == rs1_1 || (u2_1 && rd0 == rs2_1))) ||
                  (wr0 && wr1 && rd0 != 5'd0 && rd0 == rd1);
      pair_b    = has1 && !hazard && (c1 == CLS_ALU || c1 == CLS_LD || c1 == CLS_ST);
      pair_a    = has1 && !hazard && (c1 == CLS_ALU || c1 == CLS_BR);
      h0_b      = has0 && (c0 == CLS_LD || c0 == CLS_ST);
      h0_a      = has0 && !h0_b;
      g_a_valid = h0_a || (h0_b && pair_a);
      g_b_valid = h0_b || (has0 && c0 == CLS_ALU && pair_b);
      g_a_inst  = h0_a ? h0 : g_a_valid ? h1 : NOP_INST;
      g_b_inst  = h0_b ? h0 : g_b_valid ? h1 : NOP_INST;
      g_b_first = h0_b && pair_a;
      g_ill     = has0 && c0 == CLS_ILL;
      pops      = CNT_W'(g_a_valid) + CNT_W'(g_b_valid);
   end

   // queue and output register next state; flush overrides push, pop and issue
   always_comb begin
      issue = out_ready && !flush;
      push  = in_valid && in_ready && !flush;
      pop_n = issue ? pops : '0;
      mem_d = mem_q;
      if (push) mem_d[tail_q] = in_inst;
      head_d    = flush ? '0 : head_q + PTR_W'(pop_n);
      tail_d    = flush ? '0 : tail_q + PTR_W'(push);
      count_d   = flush ? '0 : count_q + CNT_W'(push) - pop_n;
      a_valid_d = flush ? 1'b0 : issue ? g_a_valid : a_valid_q;
      a_inst_d  = flush ? NOP_INST : issue ? g_a_inst : a_inst_q;
      b_valid_d = flush ? 1'b0 : issue ? g_b_valid : b_valid_q;
      b_inst_d  = flush ? NOP_INST : issue ? g_b_inst : b_inst_q;
      b_first_d = flush ? 1'b0 : issue ? g_b_first : b_first_q;
      illegal_d = issue && g_ill;
   end

   // queue storage holds data only, so it needs no reset
   always_ff @(posedge clk) mem_q <= mem_d;

   // control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         a_valid_q <= 1'b0;
         a_inst_q  <= NOP_INST;
         b_valid_q <= 1'b0;
         b_inst_q  <= NOP_INST;
         b_first_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         a_valid_q <= a_valid_d;
         a_inst_q  <= a_inst_d;
         b_valid_q <= b_valid_d;
         b_inst_q  <= b_inst_d;
         b_first_q <= b_first_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef ISSUE_STATS_EN
   logic [31:0] dual_cnt_q, dual_cnt_d, single_cnt_q, single_cnt_d;
   // issue statistics survive flush; only reset clears them
   always_comb begin
      dual_cnt_d   = dual_cnt_q + 32'(issue && pops == CNT_W'(2));
      single_cnt_d = single_cnt_q + 32'(issue && pops == CNT_W'(1));
   end
   // statistics registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dual_cnt_q   <= '0;
         single_cnt_q <= '0;
      end else begin
         dual_cnt_q   <= dual_cnt_d;
         single_cnt_q <= single_cnt_d;
      end
   end
   assign dual_cnt   = dual_cnt_q;
   assign single_cnt = single_cnt_q;
`endif

   assign in_ready    = count_q < CNT_W'(DEPTH);
   assign out_a_valid = a_valid_q;
   assign out_a_inst  = a_inst_q;
   assign out_b_valid = b_valid_q;
   assign out_b_inst  = b_inst_q;
   assign out_b_first = b_first_q;
   assign illegal     = illegal_q;
endmodule

// File: doc/dual_issue_steer.md
Name: dual_issue_steer

Overview:
- In-order issue stage feeding the two-slot decode stage: slot A (ALU/branch) and slot B (ALU/load/store).
- Buffers fetched 32-bit RV32I words in a small queue and issues up to two per cycle.
- Routes each word to a legal slot and splits a pair into single issue on register hazards.
- Drives the `input_inst` of both slot decoders from registered outputs.

Parameters:
- DEPTH, 4, queue entries; power of 2, >=2.
- PTR_W, $clog2(DEPTH), queue pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents in_inst.
- in_inst  in  32  fetched instruction.
- in_ready  out  1  queue can accept; = (count < DEPTH) from registered count, pops ignored.
- flush  in  1  discard queue and output group (redirect).
- out_ready  in  1  decode stage accepts a new group this edge.
- out_a_valid  out  1  out_a_inst is real.
- out_a_inst  out  32  slot A word; NOP 0x00000013 when not valid.
- out_b_valid  out  1  out_b_inst is real.
- out_b_inst  out  32  slot B word; NOP 0x00000013 when not valid.
- out_b_first  out  1  slot B word is program-older than slot A word.
- illegal  out  1  one-cycle pulse when an unclassified opcode is issued.

Behaviour:
- Reset, or async assertion mid-operation: queue empty, count 0, both valids 0, both insts 0x00000013, out_b_first 0, illegal 0.
- Classes by opcode [6:0]:
  - ALU: 0110011, 0010011.
  - BR: 1100011.
  - LD: 0000011.
  - ST: 0100011.
  - ILL: anything else.
- Push: in_valid & in_ready writes the tail at the edge.
- Latency: a word pushed at edge k is issued at earliest edge k+1.
- Output registers load only when out_ready=1; otherwise they hold and nothing pops.
- Group formation at each out_ready edge, from head H0 and next H1 (H1 used only if count >= 2):
  - H0 ALU -> A. H1 pairs into B if H1 is ALU/LD/ST and no hazard.
  - H0 LD/ST -> B. H1 pairs into A if H1 is ALU/BR and no hazard; out_b_first=1 when paired.
  - H0 BR -> A alone; nothing pairs after a branch.
  - H0 ILL -> A alone; illegal=1 for that cycle.
  - Empty queue: both valids 0.
  - Pops = number of valid slots loaded.
- Hazard, which forces single issue:
  - RAW: H0 writes rd (ALU/LD), rd != 0, and rd equals H1.rs1 or, where H1 uses rs2 (R-type, BR, ST), H1.rs2.
  - WAW: both write the same rd != 0.
  - ILL never pairs.
- Simultaneous push and pop in one edge is legal; count += push - pops.
- Pointers wrap modulo DEPTH.
- Full queue with out_ready=0: in_ready=0 and the push is dropped.
- flush=1, sampled at the edge, has priority over push, pop and out_ready:
  - queue and count cleared;
  - valids 0, insts NOP, illegal 0;
  - in_valid that cycle is ignored.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- When defined, adds:
  - outputs dual_cnt[31:0] and single_cnt[31:0];
  - counters increment on each out_ready edge issuing 2 or exactly 1 words;
  - counters wrap at 2^32 and clear on rst; flush does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package riscv_issue_pkg:
  - opcode constants OP_R, OP_I, OP_LD, OP_ST, OP_BR;
  - inst_class_t enum {CLS_ALU, CLS_BR, CLS_LD, CLS_ST, CLS_ILL};
  - NOP_INST = 32'h00000013.
- Sub-module inst_classify:
  - combinational, instantiated twice (H0, H1);
  - outputs class, rd, rs1, rs2, writes_rd, uses_rs2.

Test Plan:
- Reset: assert rst -> both valids 0, both insts 0x00000013, in_ready 1, illegal 0.
- Pair issue: push 0x003100B3 (add x1,x2,x3), then 0x00032283 (lw x5,0(x6)), out_ready=1 -> single group A=0x003100B3, B=0x00032283, out_b_first 0.
- RAW split: push 0x003100B3, then 0x40508233 (sub x4,x1,x5):
  - first group A=0x003100B3, B invalid;
  - next group A=0x40508233.
- Reorder pair: push 0x00112023 (sw x1,0(x2)), then 0x00418463 (beq x3,x4,8) -> B=0x00112023, A=0x00418463, out_b_first 1.
- Backpressure: out_ready=0, push 5 words -> in_ready 0 after the 4th, 5th dropped, outputs unchanged; release out_ready -> groups drain in order.
- Flush mid-operation: 3 queued, pulse flush with in_valid=1 -> next cycle valids 0, in_ready 1, later groups contain none of the flushed words.
